chan_change_logger: RTL and testbench

Parametrised, synthesizable logger for slow status signals such as LEDs, buttons and UART idle lines. It watches `NUM_CH` synchronous inputs and timestamps each qualifying change with a free-running cycle counter. Each change is queued as a record in a `DEPTH`-entry FIFO and drained over a valid/ready interface. It sits beside `ExampleTop` in simulation and on-chip, replacing per-signal ad-hoc change printing, and adds:
- edge-mode filtering;
- per-channel enables;
- timestamp-wrap markers;
- overflow accounting.

---
 rtl/chan_change_logger.sv | 144 ++++++++++++++
 tb/tb_chan_change_logger.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_change_logger.sv
// chan_change_logger
//
// Timestamped change logger for slow status signals. Each monitored channel is
// registered, compared with its previous sample and filtered by edge mode and
// per-channel enable. Every qualifying change, and every timestamp wrap,
// becomes one record in a show-ahead FIFO that is drained over valid/ready.
//
// Parameters
//   NUM_CH     number of monitored channels (1..16)
//   TS_WIDTH   free-running timestamp width (4..32)
//   DEPTH      FIFO entries, power of two, >= 2
//   EDGE_MODE  0 any change, 1 rising only, 2 falling only
//
// Ports
//   osc_clk    sole clock, rising edge
//   osc_reset  synchronous active-high reset
//   sig_in     monitored signals, already synchronous to osc_clk
//   ch_en      per-channel event enable
//   evt_valid  FIFO head holds a record
//   evt_ready  consumer accepts the head when evt_valid is high
//   evt_data   {lost, wrap, chg_mask[NUM_CH], state[NUM_CH], ts[TS_WIDTH]}
//   drop_cnt   saturating count of records rejected by a full FIFO
module chan_change_logger #(
  parameter int NUM_CH    = 3,
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic                             osc_clk,
  input  logic                             osc_reset,
  input  logic [NUM_CH-1:0]                sig_in,
  input  logic [NUM_CH-1:0]                ch_en,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [2+2*NUM_CH+TS_WIDTH-1:0]   evt_data,
  output logic [7:0]                       drop_cnt
);

  localparam int REC_W = 2 + 2*NUM_CH + TS_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  function automatic logic [NUM_CH-1:0] edge_filter(
    input logic [NUM_CH-1:0] chg_raw,
    input logic [NUM_CH-1:0] level
  );
    logic [NUM_CH-1:0] res;
    case (EDGE_MODE)
      1:       res = chg_raw & level;
      2:       res = chg_raw & ~level;
      default: res = chg_raw;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [NUM_CH-1:0]   sig_q;
  logic [NUM_CH-1:0]   prev_q;
  logic [TS_WIDTH-1:0] ts_q;
  logic                armed;
  logic                lost_q;

  logic [NUM_CH-1:0]   chg;
  logic [NUM_CH-1:0]   qual;
  logic                wrap;
  logic                push_req;
  logic                pop;
  logic                full;
  logic                accept;
  logic [REC_W-1:0]    rec;

  logic [REC_W-1:0]    mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;

  // ---- stage 0: sample inputs; prev_q trails sig_q by one cycle ----
  always_ff @(posedge osc_clk) begin
    sig_q  <= sig_in;
    prev_q <= sig_q;
  end

  // ---- stage 1: qualify changes and form the record ----
  always_comb begin
    chg      = sig_q ^ prev_q;
    qual     = edge_filter(chg, sig_q) & ch_en;
    wrap     = &ts_q;
    // armed is low in the first cycle out of reset, while prev_q is still
    // catching up with sig_q, so no startup record can be produced.
    push_req = armed & ((|qual) | wrap);
    pop      = evt_valid & evt_ready;
    full     = (count == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept   = push_req & (~full | pop);
    rec      = {lost_q, wrap, qual, sig_q, ts_q};
  end

  always_ff @(posedge osc_clk) begin
    if (osc_reset) begin
      ts_q     <= '0;
      armed    <= 1'b0;
      lost_q   <= 1'b0;
      drop_cnt <= 8'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ts_q  <= ts_q + TS_WIDTH'(1);
      armed <= 1'b1;
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
        lost_q <= 1'b0;
      end else if (push_req) begin
        lost_q   <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge osc_clk) begin
    if (accept) begin
      mem[wr_ptr] <= rec;
    end
  end

  // ---- stage 2: show-ahead FIFO head ----
  always_comb begin
    evt_valid = (count != '0);
    evt_data  = evt_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_chan_change_logger.sv
module tb_chan_change_logger;

  logic osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  int checks   = 0;
  int failures = 0;
  int tcnt     = 0;
  int pops_a   = 0;

  // dut_a: any-change, 16-bit ts. dut_f: rising-only. dut_w: 4-bit ts.
  logic        rst_a = 1'b1, rst_f = 1'b1, rst_w = 1'b1;
  logic [2:0]  sig_a = 3'b101, sig_f = 3'b000, sig_w = 3'b000;
  logic [2:0]  en_a = 3'b111, en_f = 3'b011, en_w = 3'b111;
  logic        rdy_a = 1'b1, rdy_f = 1'b1, rdy_w = 1'b1;
  logic        vld_a, vld_f, vld_w;
  logic [23:0] data_a, data_f;
  logic [11:0] data_w;
  logic [7:0]  drop_a, drop_f, drop_w;

  logic [23:0] q_a[$];
  logic [23:0] q_f[$];
  logic [11:0] q_w[$];

  chan_change_logger #(.NUM_CH(3), .TS_WIDTH(16), .DEPTH(8), .EDGE_MODE(0)) dut_a (
    .osc_clk(osc_clk), .osc_reset(rst_a), .sig_in(sig_a), .ch_en(en_a),
    .evt_valid(vld_a), .evt_ready(rdy_a), .evt_data(data_a), .drop_cnt(drop_a));

  chan_change_logger #(.NUM_CH(3), .TS_WIDTH(16), .DEPTH(8), .EDGE_MODE(1)) dut_f (
    .osc_clk(osc_clk), .osc_reset(rst_f), .sig_in(sig_f), .ch_en(en_f),
    .evt_valid(vld_f), .evt_ready(rdy_f), .evt_data(data_f), .drop_cnt(drop_f));

  chan_change_logger #(.NUM_CH(3), .TS_WIDTH(4), .DEPTH(8), .EDGE_MODE(0)) dut_w (
    .osc_clk(osc_clk), .osc_reset(rst_w), .sig_in(sig_w), .ch_en(en_w),
    .evt_valid(vld_w), .evt_ready(rdy_w), .evt_data(data_w), .drop_cnt(drop_w));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: record %0h with nothing expected", name, act);
  endtask

  function automatic logic [23:0] mk24(input logic lost, input logic wrap,
                                       input logic [2:0] mask, input logic [2:0] state,
                                       input logic [15:0] ts);
    return {lost, wrap, mask, state, ts};
  endfunction

  function automatic logic [11:0] mk12(input logic lost, input logic wrap,
                                       input logic [2:0] mask, input logic [2:0] state,
                                       input logic [3:0] ts);
    return {lost, wrap, mask, state, ts};
  endfunction

  task automatic step();
    @(posedge osc_clk);
    #1;
    tcnt++;
  endtask

  // Monitors: a pop happens at the next rising edge whenever valid&ready
  // is seen here, so each one consumes exactly one expected record.
  always @(negedge osc_clk) begin
    logic [23:0] e;
    if (!rst_a && vld_a && rdy_a) begin
      pops_a++;
      if (q_a.size() == 0) unexpected("a_rec", {8'd0, data_a});
      else begin
        e = q_a.pop_front();
        chk("a_rec", {8'd0, data_a}, {8'd0, e});
      end
    end
  end

  always @(negedge osc_clk) begin
    logic [23:0] e;
    if (!rst_f && vld_f && rdy_f) begin
      if (q_f.size() == 0) unexpected("f_rec", {8'd0, data_f});
      else begin
        e = q_f.pop_front();
        chk("f_rec", {8'd0, data_f}, {8'd0, e});
      end
    end
  end

  always @(negedge osc_clk) begin
    logic [11:0] e;
    if (!rst_w && vld_w && rdy_w) begin
      if (q_w.size() == 0) unexpected("w_rec", {20'd0, data_w});
      else begin
        e = q_w.pop_front();
        chk("w_rec", {20'd0, data_w}, {20'd0, e});
      end
    end
  end

  initial begin
    logic seen;
    int   p0;

    // Reset state
    repeat (3) step();
    chk("reset_valid", {31'd0, vld_a}, 32'd0);
    chk("reset_drop", {24'd0, drop_a}, 32'd0);
    chk("reset_data", {8'd0, data_a}, 32'd0);

    // Startup: constant 101 through release, nothing logged
    rst_a = 1'b0;
    tcnt  = 0;
    seen  = 1'b0;
    repeat (50) begin
      step();
      if (vld_a) seen = 1'b1;
    end
    chk("startup_no_valid", {31'd0, seen}, 32'd0);
    chk("startup_drop", {24'd0, drop_a}, 32'd0);

    // 101 -> 000, then latency of 000 -> 010
    sig_a = 3'b000;
    step();
    q_a.push_back(mk24(1'b0, 1'b0, 3'b101, 3'b000, tcnt[15:0]));
    repeat (4) step();
    chk("lat_idle", {31'd0, vld_a}, 32'd0);
    sig_a = 3'b010;
    step();
    chk("lat_edge_k", {31'd0, vld_a}, 32'd0);
    q_a.push_back(mk24(1'b0, 1'b0, 3'b010, 3'b010, tcnt[15:0]));
    step();
    chk("lat_edge_k1", {31'd0, vld_a}, 32'd1);
    repeat (3) step();
    chk("lat_q_empty", q_a.size(), 32'd0);

    // Overflow: 10 events into 8 slots with consumer stalled
    rdy_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sig_a = sig_a ^ 3'b001;
      step();
      if (i < 8) q_a.push_back(mk24(1'b0, 1'b0, 3'b001, sig_a, tcnt[15:0]));
    end
    repeat (2) step();
    chk("ovf_drop", {24'd0, drop_a}, 32'd2);
    chk("ovf_valid", {31'd0, vld_a}, 32'd1);
    rdy_a = 1'b1;
    repeat (10) step();
    chk("ovf_drained", q_a.size(), 32'd0);
    chk("ovf_empty", {31'd0, vld_a}, 32'd0);
    sig_a = sig_a ^ 3'b001;
    step();
    q_a.push_back(mk24(1'b1, 1'b0, 3'b001, sig_a, tcnt[15:0]));
    repeat (3) step();
    sig_a = sig_a ^ 3'b001;
    step();
    q_a.push_back(mk24(1'b0, 1'b0, 3'b001, sig_a, tcnt[15:0]));
    repeat (3) step();
    chk("lost_q_empty", q_a.size(), 32'd0);

    // Full FIFO plus simultaneous pop and push
    rdy_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sig_a = sig_a ^ 3'b001;
      step();
      q_a.push_back(mk24(1'b0, 1'b0, 3'b001, sig_a, tcnt[15:0]));
    end
    step();
    sig_a = sig_a ^ 3'b001;
    step();
    q_a.push_back(mk24(1'b0, 1'b0, 3'b001, sig_a, tcnt[15:0]));
    rdy_a = 1'b1;
    step();
    rdy_a = 1'b0;
    p0 = pops_a;
    repeat (2) step();
    chk("fullpop_drop", {24'd0, drop_a}, 32'd2);
    rdy_a = 1'b1;
    repeat (12) step();
    chk("fullpop_occupancy", pops_a - p0, 32'd8);
    chk("fullpop_q_empty", q_a.size(), 32'd0);

    // drop_cnt saturation: 8 accepted, 256 more rejected
    rdy_a = 1'b0;
    for (int i = 0; i < 264; i++) begin
      sig_a = sig_a ^ 3'b001;
      step();
      if (i < 8) q_a.push_back(mk24(1'b0, 1'b0, 3'b001, sig_a, tcnt[15:0]));
    end
    repeat (2) step();
    chk("drop_saturate", {24'd0, drop_a}, 32'd255);

    // Mid-run reset flushes the FIFO and counters
    q_a.delete();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("midreset_valid", {31'd0, vld_a}, 32'd0);
    chk("midreset_drop", {24'd0, drop_a}, 32'd0);
    chk("midreset_data", {8'd0, data_a}, 32'd0);
    rdy_a = 1'b1;
    repeat (6) step();
    chk("midreset_quiet", {31'd0, vld_a}, 32'd0);
    rst_a = 1'b1;

    // Filtering: rising-only, channel 2 disabled
    rst_f = 1'b0;
    tcnt  = 0;
    repeat (3) step();
    sig_f = 3'b001;
    step();
    q_f.push_back(mk24(1'b0, 1'b0, 3'b001, 3'b001, tcnt[15:0]));
    repeat (3) step();
    sig_f = 3'b000;
    repeat (4) step();
    sig_f = 3'b100;
    repeat (4) step();
    sig_f = 3'b101;
    step();
    q_f.push_back(mk24(1'b0, 1'b0, 3'b001, 3'b101, tcnt[15:0]));
    repeat (4) step();
    chk("filter_q_empty", q_f.size(), 32'd0);
    chk("filter_drop", {24'd0, drop_f}, 32'd0);
    rst_f = 1'b1;

    // Wrap: ts hits 15 after edges 15, 31, 47, 63 since release
    rst_w = 1'b0;
    tcnt  = 0;
    repeat (15) step();
    q_w.push_back(mk12(1'b0, 1'b1, 3'b000, 3'b000, 4'hF));
    repeat (16) step();
    q_w.push_back(mk12(1'b0, 1'b1, 3'b000, 3'b000, 4'hF));
    repeat (16) step();
    q_w.push_back(mk12(1'b0, 1'b1, 3'b000, 3'b000, 4'hF));
    repeat (15) step();
    sig_w = 3'b001;
    step();
    q_w.push_back(mk12(1'b0, 1'b1, 3'b001, 3'b001, 4'hF));
    repeat (4) step();
    chk("wrap_q_empty", q_w.size(), 32'd0);
    chk("wrap_idle", {31'd0, vld_w}, 32'd0);
    rst_w = 1'b1;

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
